triangle_fetch_unit: RTL and testbench

//  Reads triangle records (WORDS_PER_RECORD words) from on-chip sync RAM and assembles each into one wide register.

---
 rtl/triangle_fetch_if.sv | 29 ++
 rtl/triangle_fetch_unit.sv | 129 ++++++++++++
 tb/tb_triangle_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/triangle_fetch_if.sv
// Bundles the fetch unit's control, RAM-read and record-output signals.
// The slave modport is the fetch unit; the master modport is its environment.
interface triangle_fetch_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 16,
  parameter int WORDS_PER_RECORD = 9
);
  logic                                   start;
  logic                                   consumer_ready;
  logic                                   end_of_memory;
  logic [DATA_WIDTH-1:0]                  mem_rdata;
  logic                                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]                  mem_addr;
  logic [DATA_WIDTH*WORDS_PER_RECORD-1:0] record_data;
  logic                                   fetch_data_ready;
  logic                                   busy;
  logic                                   done;
  logic                                   addr_overflow;

  modport master (
    output start, consumer_ready, end_of_memory, mem_rdata,
    input  mem_rd_en, mem_addr, record_data, fetch_data_ready, busy, done, addr_overflow
  );

  modport slave (
    input  start, consumer_ready, end_of_memory, mem_rdata,
    output mem_rd_en, mem_addr, record_data, fetch_data_ready, busy, done, addr_overflow
  );
endinterface

// File: rtl/triangle_fetch_unit.sv
// Triangle fetch unit: streams fixed-size triangle records out of a
// synchronous vertex RAM, assembles each into one wide register and pulses
// fetch_data_ready once per completed record.
module triangle_fetch_unit #(
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    ADDR_WIDTH       = 16,
  parameter int                    WORDS_PER_RECORD = 9,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR         = 16'hFFFF
) (
  input logic             clk,
  input logic             rst,
  triangle_fetch_if.slave bus
);

  localparam int W     = WORDS_PER_RECORD;
  localparam int CNT_W = $clog2(W + 1);
  localparam int REC_W = DATA_WIDTH * W;

  // One extra address bit so the counter can step past MAX_ADDR without wrapping.
  localparam logic [ADDR_WIDTH:0] MAX_EXT   = {1'b0, MAX_ADDR};
  localparam logic [ADDR_WIDTH:0] LAST_OFS  = (ADDR_WIDTH + 1)'(W - 1);
  localparam bit                  START_OVF = (LAST_OFS > MAX_EXT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    PULSE,
    HOLD,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     addr_q, addr_d;
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
  logic                    ovf_q, ovf_d;
  logic [REC_W-1:0]        record_q, record_d;
  logic [DATA_WIDTH-1:0]   shadow_q [W];
  logic [DATA_WIDTH-1:0]   shadow_d [W];
  logic [REC_W-1:0]        shadow_flat;
  logic                    cap_en;
  logic                    next_rec_over;

  // Data for read k arrives one cycle later, i.e. while word_cnt_q == k+1
  // (the final word lands during DRAIN).
  assign cap_en        = ((state_q == FETCH) && (word_cnt_q != '0)) || (state_q == DRAIN);
  assign next_rec_over = (addr_q + LAST_OFS) > MAX_EXT;

  // Shadow buffer: one register per word, written as its read data returns.
  for (genvar gi = 0; gi < W; gi++) begin : g_shadow
    assign shadow_d[gi] = (cap_en && (word_cnt_q == CNT_W'(gi + 1))) ? bus.mem_rdata : shadow_q[gi];
    assign shadow_flat[gi*DATA_WIDTH +: DATA_WIDTH] = shadow_d[gi];

    // Shadow word register; a reset discards any partial record.
    always_ff @(posedge clk) begin
      if (!rst) shadow_q[gi] <= '0;
      else      shadow_q[gi] <= shadow_d[gi];
    end
  end

  // Next-state, address/word counting and record load.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    ovf_d      = ovf_q;
    record_d   = record_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          addr_d     = '0;
          word_cnt_d = '0;
          ovf_d      = START_OVF;
          state_d    = START_OVF ? DONE : FETCH;
        end
      end
      FETCH: begin
        addr_d     = addr_q + (ADDR_WIDTH + 1)'(1);
        word_cnt_d = word_cnt_q + CNT_W'(1);
        if (word_cnt_q == CNT_W'(W - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        record_d = shadow_flat;
        state_d  = PULSE;
      end
      PULSE, HOLD: begin
        word_cnt_d = '0;
        if (bus.end_of_memory) begin
          state_d = DONE;
        end else if ((state_q == PULSE) && next_rec_over) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else if (bus.consumer_ready) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      ovf_q      <= 1'b0;
      record_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      ovf_q      <= ovf_d;
      record_q   <= record_d;
    end
  end

  assign bus.mem_rd_en        = (state_q == FETCH);
  assign bus.mem_addr         = addr_q[ADDR_WIDTH-1:0];
  assign bus.record_data      = record_q;
  assign bus.fetch_data_ready = (state_q == PULSE);
  assign bus.busy             = (state_q == FETCH) || (state_q == DRAIN) ||
                                (state_q == PULSE) || (state_q == HOLD);
  assign bus.done             = (state_q == DONE);
  assign bus.addr_overflow    = ovf_q;

endmodule

// File: tb/tb_triangle_fetch_unit.sv
// Self-checking bench for triangle_fetch_unit: table of randomized jobs
// checked cycle by cycle against a record-level model, plus hand-written
// sequences for the address-limit and mid-fetch reset cases.
module tb_triangle_fetch_unit;

  localparam int DW         = 32;
  localparam int W          = 9;
  localparam int REC_W      = DW * W;
  localparam int MAX_MAIN   = 65535;
  localparam int JOB_BUDGET = 5000;
  localparam logic [15:0] SMALL_SEED = 16'h0BEE;

  typedef struct {
    int seed;
    int eom_after;     // counter raises end_of_memory after this many pulses
    int cr_pct;        // chance consumer_ready is high in a waiting cycle
    int eom_hold_pct;  // chance end_of_memory appears while waiting
    int hold_first;    // forced consumer_ready=0 cycles after the first pulse
    int exp_pulses;    // expected pulse count, -1 if stimulus-dependent
  } vec_t;

  logic clk;
  logic rst;
  logic [15:0] seed;
  logic [REC_W-1:0] exp_record;
  int vectors;
  int miscompares;
  vec_t vecs [6];

  triangle_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .WORDS_PER_RECORD(W)) bus ();
  triangle_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .WORDS_PER_RECORD(W)) bus_s ();

  triangle_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  triangle_fetch_unit #(.MAX_ADDR(16'd20)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [15:0] a, input logic [15:0] s);
    return {s, a};
  endfunction

  function automatic logic [REC_W-1:0] model_record(input int base);
    logic [REC_W-1:0] r;
    r = '0;
    for (int k = 0; k < W; k++) r[k*DW +: DW] = ram_word(16'(base + k), seed);
    return r;
  endfunction

  // Synchronous RAMs: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (!rst)                bus.mem_rdata <= '0;
    else if (bus.mem_rd_en)  bus.mem_rdata <= ram_word(bus.mem_addr, seed);
  end

  always @(posedge clk) begin
    if (!rst)                 bus_s.mem_rdata <= '0;
    else if (bus_s.mem_rd_en) bus_s.mem_rdata <= ram_word(bus_s.mem_addr, SMALL_SEED);
  end

  task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_record"}, bus.record_data, 0);
    chk({tag, "_ready"}, bus.fetch_data_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_ovf"}, bus.addr_overflow, 0);
  endtask

  // One job on the main unit: start, then model every cycle until done.
  task automatic run_job(input int row);
    vec_t v;
    int next_addr, reads_left, pulse_at, rec_base, pulses, hold_cnt, fin_at;
    bit waiting, finished, ovf_exp, ended, exp_done;
    v = vecs[row];
    seed = v.seed[15:0];
    bus.start = 1'b1;
    bus.end_of_memory = 1'b0;
    bus.consumer_ready = 1'b0;
    next_addr = 0; reads_left = W; pulse_at = -1; rec_base = 0; pulses = 0;
    hold_cnt = 0; fin_at = 0; waiting = 0; finished = 0; ovf_exp = 0; ended = 0;
    for (int c = 1; c < JOB_BUDGET; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("mem_rd_en", bus.mem_rd_en, reads_left > 0);
      if (reads_left > 0) begin
        chk("mem_addr", bus.mem_addr, next_addr[15:0]);
        next_addr++;
        reads_left--;
        if (reads_left == 0) pulse_at = c + 2;
      end
      chk("fetch_data_ready", bus.fetch_data_ready, c == pulse_at);
      if (c == pulse_at) begin
        exp_record = model_record(rec_base);
        pulses++;
      end
      chk("record_data", bus.record_data, exp_record);
      exp_done = finished && (c >= fin_at);
      chk("done", bus.done, exp_done);
      chk("busy", bus.busy, !exp_done);
      chk("addr_overflow", bus.addr_overflow, ovf_exp && exp_done);
      if (finished) begin
        if (c >= fin_at + 4) begin
          ended = 1;
          break;
        end
      end else if (c == pulse_at) begin
        if (pulses >= v.eom_after) begin
          bus.end_of_memory = 1'b1;
          finished = 1; fin_at = c + 1;
        end else if (next_addr + W - 1 > MAX_MAIN) begin
          finished = 1; ovf_exp = 1; fin_at = c + 1;
        end else begin
          waiting = 1;
          hold_cnt = (pulses == 1) ? v.hold_first + 1 : 0;
        end
      end
      if (waiting) begin
        if (c != pulse_at && hold_cnt == 0 && $urandom_range(99) < v.eom_hold_pct) begin
          bus.end_of_memory = 1'b1;
          bus.consumer_ready = 1'($urandom_range(1));
          finished = 1; fin_at = c + 1; waiting = 0;
        end else begin
          if (hold_cnt > 0) begin
            bus.consumer_ready = 1'b0;
            hold_cnt--;
          end else begin
            bus.consumer_ready = ($urandom_range(99) < v.cr_pct);
          end
          if (bus.consumer_ready) begin
            waiting = 0; reads_left = W; rec_base = next_addr;
          end
        end
      end
    end
    if (!ended) begin
      vectors++;
      miscompares++;
      $display("FAIL job%0d_timeout: got no completion, expected done within %0d cycles", row, JOB_BUDGET);
    end
    if (v.exp_pulses >= 0) chk("pulse_count", pulses, v.exp_pulses);
    $display("job %0d: seed=%0h pulses=%0d", row, v.seed, pulses);
  endtask

  // Small address space: records at 0 and 9 only, then overflow stop and restart.
  task automatic small_dut_seq();
    int reads, pulses, bad_addr;
    bit seen_done;
    bus_s.start = 1'b1;
    bus_s.consumer_ready = 1'b1;
    bus_s.end_of_memory = 1'b0;
    reads = 0; pulses = 0; bad_addr = 0; seen_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      bus_s.start = 1'b0;
      if (bus_s.mem_rd_en) begin
        if (int'(bus_s.mem_addr) != reads) bad_addr++;
        reads++;
      end
      if (bus_s.fetch_data_ready) begin
        pulses++;
        if (pulses == 2) begin
          chk("small_rec2_w0", bus_s.record_data[0 +: DW], ram_word(16'd9, SMALL_SEED));
          chk("small_rec2_w8", bus_s.record_data[8*DW +: DW], ram_word(16'd17, SMALL_SEED));
        end
      end
      if (bus_s.done) begin
        seen_done = 1;
        break;
      end
    end
    chk("small_done", seen_done, 1);
    chk("small_pulses", pulses, 2);
    chk("small_reads", reads, 18);
    chk("small_addr_seq", bad_addr, 0);
    chk("small_ovf", bus_s.addr_overflow, 1);
    @(posedge clk); #1;
    chk("small_idle_rd", bus_s.mem_rd_en, 0);
    bus_s.start = 1'b1;
    @(posedge clk); #1;
    bus_s.start = 1'b0;
    chk("small_restart_ovf", bus_s.addr_overflow, 0);
    chk("small_restart_rd", bus_s.mem_rd_en, 1);
    chk("small_restart_addr", bus_s.mem_addr, 0);
    $display("small: pulses=%0d reads=%0d", pulses, reads);
  endtask

  // Reset asserted while word 4 of a record is being read.
  task automatic reset_mid_fetch();
    bit found;
    seed = 16'h1234;
    bus.start = 1'b1;
    bus.end_of_memory = 1'b0;
    bus.consumer_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.mem_rd_en && bus.mem_addr == 16'd4) begin
        found = 1;
        break;
      end
    end
    chk("rst_reach_word4", found, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("rst_mid");
    rst = 1'b1;
    exp_record = '0;
    $display("reset mid-fetch applied");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_record = '0;
    seed = '0;
    rst = 1'b0;
    bus.start = 1'b0; bus.consumer_ready = 1'b0; bus.end_of_memory = 1'b0;
    bus_s.start = 1'b0; bus_s.consumer_ready = 1'b0; bus_s.end_of_memory = 1'b0;

    vecs[0] = '{0,                        186, 100, 0,  0,  186};
    vecs[1] = '{int'($urandom_range(65535)), 2, 100, 0,  20, 2};
    vecs[2] = '{int'($urandom_range(65535)), 6, 35,  0,  0,  6};
    vecs[3] = '{int'($urandom_range(65535)), 40, 40, 25, 0,  -1};
    vecs[4] = '{int'($urandom_range(65535)), 1, 0,   0,  0,  1};
    vecs[5] = '{int'($urandom_range(65535)), 4, 60,  0,  0,  4};

    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 5; r++) run_job(r);
    small_dut_seq();
    reset_mid_fetch();
    run_job(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
